multiword_sub_sequencer: RTL and testbench
==========================================

MULTIWORD_SUB_SEQUENCER -- requirements
Module: multiword_sub_sequencer

Interface
REQ-001 The block SHALL have parameter nrOfBits, default 8, giving the word width in bits.
REQ-002 The block SHALL have parameter nrOfWords, default 4, giving the words per operand (minimum 2).
REQ-003 Port clock, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-005 Port clear, input, 1 bit, SHALL be a synchronous abort of the current operation.
REQ-006 Port in_valid, input, 1 bit, SHALL flag that an operand word pair is present.
REQ-007 Port in_ready, output, 1 bit, SHALL flag that the block can accept a word pair.
REQ-008 Port dataA, input, nrOfBits, SHALL carry the minuend word, least-significant word first.
REQ-009 Port dataB, input, nrOfBits, SHALL carry the subtrahend word, least-significant word first.
REQ-010 Port out_valid, output, 1 bit, SHALL flag that a result word is held.
REQ-011 Port out_ready, input, 1 bit, SHALL flag that the consumer accepts the result word.
REQ-012 Port result, output, nrOfBits, SHALL carry the difference word.
REQ-013 Port out_last, output, 1 bit, SHALL mark the most-significant result word of an operation.
REQ-014 Port borrowOut, output, 1 bit, SHALL carry the final borrow; valid with out_last (1 = A<B unsigned).
REQ-015 Port zeroOut, output, 1 bit, SHALL carry the all-words-zero flag; valid with out_last (1 = A==B).

Function
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer when out_valid and out_ready are both high.
REQ-017 in_ready SHALL equal (!out_valid || out_ready) && !clear.
REQ-018 On each input transfer the block SHALL register result = dataA - dataB - borrow_reg, modulo 2^nrOfBits, and set out_valid, giving 1-cycle latency.
REQ-019 borrow_reg SHALL be forced to 0 for word index 0 and SHALL take the borrow of the current word on every input transfer.
REQ-020 The word counter SHALL run 0..nrOfWords-1 and advance on each input transfer, wrapping to 0 after index nrOfWords-1.
REQ-021 The state machine SHALL have states IDLE and BUSY: IDLE->BUSY on the word-0 transfer; BUSY->IDLE on the word nrOfWords-1 transfer.
REQ-022 out_last SHALL be 1 exactly for the registered word of index nrOfWords-1.
REQ-023 borrowOut SHALL equal that word's borrow while out_last is 1, and 0 otherwise.
REQ-024 result, out_last, borrowOut and zeroOut SHALL hold stable while out_valid is high and out_ready is low.
REQ-025 When an output transfer and an input transfer occur in the same cycle, the new word SHALL replace the old one with no bubble.
REQ-026 A new operation SHALL be accepted the cycle after the last word, with no idle cycle required.
REQ-027 clear SHALL, at the next edge, drop out_valid, discard any held word, zero the counter and borrow, and return to IDLE; an accompanying input word is not accepted.

Reset
REQ-028 While reset_n is low, out_valid, result, out_last, borrowOut, zeroOut, borrow_reg, the counter and the zero accumulator SHALL be 0, and the state SHALL be IDLE.
REQ-029 in_ready SHALL be 1 during and after reset.
REQ-030 Reset asserted mid-operation SHALL discard partial results; the next accepted word SHALL be word 0.

Configuration
REQ-031 With macro SUBSEQ_ZERO_FLAG_EN defined, the block SHALL AND a per-word (result==0) term into a zero accumulator, set to 1 at word 0, and drive zeroOut with it when out_last is 1.
REQ-032 Without SUBSEQ_ZERO_FLAG_EN, zeroOut SHALL be tied to 0 and the zero accumulator logic SHALL be absent.

Verification (nrOfBits=8, nrOfWords=4, SUBSEQ_ZERO_FLAG_EN defined)
REQ-033 A=0x00000100, B=0x00000001 -> result words FF,00,00,00; borrowOut=0, zeroOut=0.
REQ-034 A=B=0x12345678 -> result words 00,00,00,00; borrowOut=0, zeroOut=1.
REQ-035 A=0x00000000, B=0x00000001 -> result words FF,FF,FF,FF; borrowOut=1, zeroOut=0.
REQ-036 out_ready held low 3 cycles after word 0 -> in_ready=0 and result=FF held stable; words resume afterwards with an identical final result.
REQ-037 reset_n pulsed low after 2 words -> out_valid=0 at once; the following 4 words (A=5, B=3) give 02,00,00,00 with borrowOut=0.
REQ-038 Back-to-back operations at full rate with out_ready=1 -> one result per cycle, out_last on every 4th word, no bubbles.

Source files
------------

// File: rtl/multiword_sub_sequencer.sv
// Word-serial multi-word subtractor: A - B streamed LS word first, one result word per accepted pair.
// Optional SUBSEQ_ZERO_FLAG_EN adds an all-words-zero accumulator that drives zeroOut on the last word.
//
// state | meaning
// IDLE  | waiting for word 0 of a new operation
// BUSY  | words 1..nrOfWords-1 of the current operation outstanding
module multiword_sub_sequencer #(
    parameter int nrOfBits  = 8,
    parameter int nrOfWords = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [nrOfBits-1:0] dataA,
    input  logic [nrOfBits-1:0] dataB,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [nrOfBits-1:0] result,
    output logic                out_last,
    output logic                borrowOut,
    output logic                zeroOut
);

    localparam int CNT_W = $clog2(nrOfWords);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(nrOfWords - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [CNT_W-1:0]   word_cnt;
    logic               borrow_reg;
    logic               in_xfer;
    logic               first_word;
    logic               last_word;
    logic               borrow_in;
    logic [nrOfBits:0]  diff;

    assign in_ready   = (!out_valid || out_ready) && !clear;
    assign in_xfer    = in_valid && in_ready;
    assign first_word = (word_cnt == '0);
    assign last_word  = (word_cnt == LAST_IDX);
    assign borrow_in  = first_word ? 1'b0 : borrow_reg;
    // Extra MSB of the widened difference is the borrow out of this word.
    assign diff = {1'b0, dataA} - {1'b0, dataB} - {{nrOfBits{1'b0}}, borrow_in};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            word_cnt   <= '0;
            borrow_reg <= 1'b0;
            out_valid  <= 1'b0;
            result     <= '0;
            out_last   <= 1'b0;
            borrowOut  <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            word_cnt   <= '0;
            borrow_reg <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            borrowOut  <= 1'b0;
        end else if (in_xfer) begin
            result     <= diff[nrOfBits-1:0];
            out_valid  <= 1'b1;
            out_last   <= last_word;
            borrowOut  <= last_word & diff[nrOfBits];
            borrow_reg <= diff[nrOfBits];
            word_cnt   <= last_word ? '0 : word_cnt + 1'b1;
            case (state)
                IDLE:    if (first_word) state <= BUSY;
                BUSY:    if (last_word) state <= IDLE;
                default: state <= IDLE;
            endcase
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SUBSEQ_ZERO_FLAG_EN
    logic zero_acc;
    logic zero_next;

    assign zero_next = (first_word ? 1'b1 : zero_acc) & (diff[nrOfBits-1:0] == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zero_acc <= 1'b0;
            zeroOut  <= 1'b0;
        end else if (clear) begin
            zero_acc <= 1'b0;
            zeroOut  <= 1'b0;
        end else if (in_xfer) begin
            zero_acc <= zero_next;
            zeroOut  <= last_word & zero_next;
        end
    end
`else
    assign zeroOut = 1'b0;
`endif

endmodule

// File: tb/tb_multiword_sub_sequencer.sv
// Directed bench for multiword_sub_sequencer (8-bit words, 4 words): scoreboard of whole-operand
// differences, checked word by word as results leave the block.
module tb_multiword_sub_sequencer;

    localparam int W = 8;
    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] dataA = '0;
    logic [W-1:0] dataB = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         out_last;
    logic         borrowOut;
    logic         zeroOut;

    multiword_sub_sequencer #(.nrOfBits(W), .nrOfWords(N)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .dataA(dataA), .dataB(dataB),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_last(out_last),
        .borrowOut(borrowOut), .zeroOut(zeroOut)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] res;
        logic         last;
        logic         brw;
        logic         zro;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each held word transfers at the next rising edge, so it is checked exactly once here.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("result", 32'(result), 32'(mon_e.res));
                check("out_last", 32'(out_last), 32'(mon_e.last));
                check("borrowOut", 32'(borrowOut), 32'(mon_e.brw));
                if (mon_e.last) check("zeroOut", 32'(zeroOut), 32'(mon_e.zro));
            end
        end
    end

    task automatic push_op(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        exp_t        e;
        d = a - b;
        for (int i = 0; i < N; i++) begin
            e.res  = d[8*i +: 8];
            e.last = (i == N - 1);
            e.brw  = (i == N - 1) && (a < b);
`ifdef SUBSEQ_ZERO_FLAG_EN
            e.zro  = (i == N - 1) && (a == b);
`else
            e.zro  = 1'b0;
`endif
            sb.push_back(e);
        end
    endtask

    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        dataA = a;
        dataB = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_op(input logic [31:0] a, input logic [31:0] b);
        push_op(a, b);
        for (int i = 0; i < N; i++) send_word(a[8*i +: 8], b[8*i +: 8]);
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) break;
            @(posedge clock);
            #1;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int c0;

        // reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_borrowOut", 32'(borrowOut), 32'd0);
        check("rst_zeroOut", 32'(zeroOut), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // reference vectors
        send_op(32'h0000_0100, 32'h0000_0001);
        send_op(32'h1234_5678, 32'h1234_5678);
        send_op(32'h0000_0000, 32'h0000_0001);
        drain();

        // back-to-back at full rate
        c0 = cyc;
        send_op(32'hFFFF_FFFF, 32'h0000_0000);
        send_op($urandom, $urandom);
        send_op(32'h0000_0000, 32'hFFFF_FFFF);
        check("b2b_cycles", 32'(cyc - c0), 32'd12);
        drain();

        // consumer stall after word 0
        push_op(32'h0000_0100, 32'h0000_0001);
        send_word(8'h00, 8'h01);
        out_ready = 1'b0;
        in_valid = 1'b1;
        dataA = 8'h01;
        dataB = 8'h00;
        repeat (3) begin
            @(negedge clock);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_result", 32'(result), 32'h0000_00FF);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        send_word(8'h01, 8'h00);
        send_word(8'h00, 8'h00);
        send_word(8'h00, 8'h00);
        drain();

        // reset mid-operation
        push_op(32'hAABB_CCDD, 32'h1122_3344);
        send_word(8'hDD, 8'h44);
        send_word(8'hCC, 8'h33);
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        send_op(32'h0000_0005, 32'h0000_0003);
        drain();

        // synchronous clear mid-operation
        push_op(32'h0100_0000, 32'h0000_0002);
        send_word(8'h00, 8'h02);
        send_word(8'h00, 8'h00);
        clear = 1'b1;
        in_valid = 1'b1;
        dataA = 8'h09;
        dataB = 8'h01;
        @(negedge clock);
        check("clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_out_valid", 32'(out_valid), 32'd0);
        sb.delete();
        send_op(32'h0000_0009, 32'h0000_0001);
        drain();

        @(posedge clock);
        #1;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
